// File: rtl/ysyx_220053_hazard_pkg.sv
// Shared types and helpers for the ysyx_220053 hazard/forwarding unit.
package ysyx_220053_hazard_pkg;

    localparam int NREG_DEF = 32;
    localparam int RW       = $clog2(NREG_DEF);

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_STAGE,
        FWD_CPL
    } fwd_sel_e;

    // Bit offset of stage idx inside a packed per-stage bus.
    function automatic int stage_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ysyx_220053_hazard_scoreboard_fwd_resolve.sv
// One source operand: stage match, forward priority, ready check, data mux.
module ysyx_220053_fwd_resolve
    import ysyx_220053_hazard_pkg::*;
#(
    parameter  int NREG   = 32,
    parameter  int XLEN   = 64,
    parameter  int NSTAGE = 3,
    localparam int IW     = $clog2(NREG)
) (
    input  logic                   src_use_i,
    input  logic [IW-1:0]          src_idx_i,
    input  logic                   src_busy_i,
    input  logic [XLEN-1:0]        rf_data_i,
    input  logic [NSTAGE-1:0]      st_valid_i,
    input  logic [NSTAGE-1:0]      st_wen_i,
    input  logic [NSTAGE-1:0]      st_ready_i,
    input  logic [NSTAGE*IW-1:0]   st_rd_i,
    input  logic [NSTAGE*XLEN-1:0] st_data_i,
    input  logic                   cpl_valid_i,
    input  logic [IW-1:0]          cpl_rd_i,
    input  logic [XLEN-1:0]        cpl_data_i,
    output logic                   need_stall_o,
    output logic [XLEN-1:0]        data_o
);

    logic            act;
    logic            hit;
    logic            hit_rdy;
    logic [XLEN-1:0] hit_data;
    fwd_sel_e        sel;

    assign act = src_use_i && (src_idx_i != '0);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (st_valid_i[i] && st_wen_i[i] &&
                st_rd_i[stage_lsb(i, IW) +: IW] == src_idx_i) begin
                hit      = 1'b1;
                hit_rdy  = st_ready_i[i];
                hit_data = st_data_i[stage_lsb(i, XLEN) +: XLEN];
            end
        end
    end

    always_comb begin
        sel = FWD_RF;
        if (act && hit) begin
            sel = FWD_STAGE;
        end else if (act && cpl_valid_i && cpl_rd_i == src_idx_i) begin
            sel = FWD_CPL;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        unique case (sel)
            FWD_STAGE: data_o = hit_data;
            FWD_CPL:   data_o = cpl_data_i;
            default:   data_o = rf_data_i;
        endcase
    end

    assign need_stall_o = act && (hit ? !hit_rdy : src_busy_i);

endmodule

// File: rtl/ysyx_220053_hazard_scoreboard.sv
// ID-stage hazard unit: per-operand forwarding plus a long-latency scoreboard.
module ysyx_220053_hazard_scoreboard
    import ysyx_220053_hazard_pkg::*;
#(
    parameter  int NREG    = 32,
    parameter  int XLEN    = 64,
    parameter  int NSTAGE  = 3,
    parameter  int MAX_OUT = 4,
    localparam int IW      = $clog2(NREG),
    localparam int OW      = $clog2(MAX_OUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_en,
    input  logic [IW-1:0]          id_rs1,
    input  logic [IW-1:0]          id_rs2,
    input  logic                   id_rs1_use,
    input  logic                   id_rs2_use,
    input  logic [IW-1:0]          id_rd,
    input  logic                   id_rd_wen,
    input  logic                   id_long,
    input  logic [XLEN-1:0]        rf_rs1_data,
    input  logic [XLEN-1:0]        rf_rs2_data,
    input  logic [NSTAGE-1:0]      st_valid,
    input  logic [NSTAGE-1:0]      st_wen,
    input  logic [NSTAGE-1:0]      st_ready,
    input  logic [NSTAGE*IW-1:0]   st_rd,
    input  logic [NSTAGE*XLEN-1:0] st_data,
    input  logic                   cpl_valid,
    input  logic [IW-1:0]          cpl_rd,
    input  logic [XLEN-1:0]        cpl_data,
    output logic                   stall,
    output logic                   issue_fire,
    output logic [XLEN-1:0]        op1_data,
    output logic [XLEN-1:0]        op2_data,
    output logic [OW-1:0]          outstanding,
    output logic [31:0]            stall_cnt,
    output logic                   err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [OW-1:0]   out_q, out_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [NREG-1:0] cpl_mask;
    logic [NREG-1:0] busy_eff;
    logic            s1_stall, s2_stall;
    logic            waw, full;
    logic            retire, alloc;

    assign cpl_mask = cpl_valid ? (NREG'(1) << cpl_rd) : '0;
    assign busy_eff = busy_q & ~cpl_mask;

    ysyx_220053_fwd_resolve #(
        .NREG   (NREG),
        .XLEN   (XLEN),
        .NSTAGE (NSTAGE)
    ) u_rs1 (
        .src_use_i    (id_rs1_use),
        .src_idx_i    (id_rs1),
        .src_busy_i   (busy_eff[id_rs1]),
        .rf_data_i    (rf_rs1_data),
        .st_valid_i   (st_valid),
        .st_wen_i     (st_wen),
        .st_ready_i   (st_ready),
        .st_rd_i      (st_rd),
        .st_data_i    (st_data),
        .cpl_valid_i  (cpl_valid),
        .cpl_rd_i     (cpl_rd),
        .cpl_data_i   (cpl_data),
        .need_stall_o (s1_stall),
        .data_o       (op1_data)
    );

    ysyx_220053_fwd_resolve #(
        .NREG   (NREG),
        .XLEN   (XLEN),
        .NSTAGE (NSTAGE)
    ) u_rs2 (
        .src_use_i    (id_rs2_use),
        .src_idx_i    (id_rs2),
        .src_busy_i   (busy_eff[id_rs2]),
        .rf_data_i    (rf_rs2_data),
        .st_valid_i   (st_valid),
        .st_wen_i     (st_wen),
        .st_ready_i   (st_ready),
        .st_rd_i      (st_rd),
        .st_data_i    (st_data),
        .cpl_valid_i  (cpl_valid),
        .cpl_rd_i     (cpl_rd),
        .cpl_data_i   (cpl_data),
        .need_stall_o (s2_stall),
        .data_o       (op2_data)
    );

    assign retire = cpl_valid && busy_q[cpl_rd];
    assign waw    = id_rd_wen && (id_rd != '0) && busy_eff[id_rd];
    // Only a completion that really retires a busy register frees a slot.
    assign full   = id_long && (out_q == OW'(MAX_OUT)) && !retire;

    assign stall      = id_valid && (s1_stall || s2_stall || waw || full);
    assign issue_fire = id_valid && id_en && !stall;
    assign alloc      = issue_fire && id_long && id_rd_wen && (id_rd != '0);

    always_comb begin
        busy_d = busy_q;
        out_d  = out_q;
        if (retire) begin
            busy_d[cpl_rd] = 1'b0;
        end
        if (alloc) begin
            busy_d[id_rd] = 1'b1;
        end
        unique case ({alloc, retire})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    assign cnt_d = (stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    assign err_d = err_q || (cpl_valid && !busy_q[cpl_rd]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign outstanding = out_q;
    assign stall_cnt   = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ysyx_220053_hazard_scoreboard.sv
// Self-checking bench for ysyx_220053_hazard_scoreboard (MAX_OUT=2).
module tb_ysyx_220053_hazard_scoreboard;

    localparam int NS   = 3;
    localparam int XL   = 64;
    localparam int RW   = 5;
    localparam int MAXO = 2;
    localparam int OW   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             id_valid, id_en;
    logic [RW-1:0]    id_rs1, id_rs2, id_rd;
    logic             id_rs1_use, id_rs2_use, id_rd_wen, id_long;
    logic [XL-1:0]    rf_rs1_data, rf_rs2_data;
    logic [NS-1:0]    st_valid, st_wen, st_ready;
    logic [NS*RW-1:0] st_rd;
    logic [NS*XL-1:0] st_data;
    logic             cpl_valid;
    logic [RW-1:0]    cpl_rd;
    logic [XL-1:0]    cpl_data;
    logic             stall, issue_fire;
    logic [XL-1:0]    op1_data, op2_data;
    logic [OW-1:0]    outstanding;
    logic [31:0]      stall_cnt;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          mbusy[32];
    int          mout;
    int unsigned mcnt;
    bit          merr;
    logic        e_stall, e_fire;
    logic [XL-1:0] e_op1, e_op2;

    ysyx_220053_hazard_scoreboard #(
        .NREG(32), .XLEN(XL), .NSTAGE(NS), .MAX_OUT(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_en(id_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_long(id_long),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .st_valid(st_valid), .st_wen(st_wen), .st_ready(st_ready),
        .st_rd(st_rd), .st_data(st_data),
        .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .cpl_data(cpl_data),
        .stall(stall), .issue_fire(issue_fire),
        .op1_data(op1_data), .op2_data(op2_data),
        .outstanding(outstanding), .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy(input logic [RW-1:0] r);
        return mbusy[r] && !(cpl_valid && cpl_rd == r);
    endfunction

    task automatic m_src(input logic [RW-1:0] rs, input logic u,
                         input logic [XL-1:0] rf,
                         output logic [XL-1:0] d, output logic s);
        d = rf;
        s = 1'b0;
        if (!u || rs == 0) return;
        for (int i = 0; i < NS; i++) begin
            if (st_valid[i] && st_wen[i] && st_rd[i*RW +: RW] == rs) begin
                d = st_data[i*XL +: XL];
                s = !st_ready[i];
                return;
            end
        end
        if (cpl_valid && cpl_rd == rs) d = cpl_data;
        s = m_busy(rs);
    endtask

    task automatic m_comb();
        logic s1, s2, waw, full;
        m_src(id_rs1, id_rs1_use, rf_rs1_data, e_op1, s1);
        m_src(id_rs2, id_rs2_use, rf_rs2_data, e_op2, s2);
        waw  = id_rd_wen && id_rd != 0 && m_busy(id_rd);
        full = id_long && mout == MAXO && !(cpl_valid && mbusy[cpl_rd]);
        e_stall = id_valid && (s1 || s2 || waw || full);
        e_fire  = id_valid && id_en && !e_stall;
    endtask

    task automatic m_reset();
        foreach (mbusy[r]) mbusy[r] = 1'b0;
        mout = 0;
        mcnt = 0;
        merr = 1'b0;
    endtask

    task automatic tick();
        m_comb();
        if (cpl_valid) begin
            if (mbusy[cpl_rd]) begin
                mbusy[cpl_rd] = 1'b0;
                mout--;
            end else begin
                merr = 1'b1;
            end
        end
        if (e_fire && id_long && id_rd_wen && id_rd != 0) begin
            mbusy[id_rd] = 1'b1;
            mout++;
        end
        if (e_stall && mcnt != 32'hFFFF_FFFF) mcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_valid = 0; id_en = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_use = 0; id_rs2_use = 0; id_rd = 0; id_rd_wen = 0;
        id_long = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        st_valid = 0; st_wen = 0; st_ready = 0; st_rd = 0; st_data = 0;
        cpl_valid = 0; cpl_rd = 0; cpl_data = 0;
    endtask

    task automatic set_stage(input int i, input logic v, input logic w,
                             input logic r, input logic [RW-1:0] rd,
                             input logic [XL-1:0] d);
        st_valid[i] = v;
        st_wen[i]   = w;
        st_ready[i] = r;
        st_rd[i*RW +: RW] = rd;
        st_data[i*XL +: XL] = d;
    endtask

    task automatic set_id(input logic v, input logic en,
                          input logic [RW-1:0] r1, input logic u1,
                          input logic [RW-1:0] r2, input logic u2,
                          input logic [RW-1:0] rd, input logic wen,
                          input logic lng);
        id_valid = v; id_en = en;
        id_rs1 = r1; id_rs1_use = u1;
        id_rs2 = r2; id_rs2_use = u2;
        id_rd = rd; id_rd_wen = wen; id_long = lng;
    endtask

    task automatic set_cpl(input logic v, input logic [RW-1:0] rd,
                           input logic [XL-1:0] d);
        cpl_valid = v; cpl_rd = rd; cpl_data = d;
    endtask

    task automatic test_reset();
        clear_in();
        #1 rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %0b exp 0", stall); end
        n_cmp++; if (issue_fire !== 1'b0) begin n_bad++; $display("FAIL rst_fire got %0b exp 0", issue_fire); end
        n_cmp++; if (op1_data !== 64'h0) begin n_bad++; $display("FAIL rst_op1 got %h exp 0", op1_data); end
        n_cmp++; if (op2_data !== 64'h0) begin n_bad++; $display("FAIL rst_op2 got %h exp 0", op2_data); end
        n_cmp++; if (outstanding !== '0) begin n_bad++; $display("FAIL rst_out got %0d exp 0", outstanding); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got %0d exp 0", stall_cnt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b exp 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_fwd_priority();
        clear_in();
        set_id(1, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
        rf_rs1_data = 64'h5555;
        set_stage(0, 1, 1, 1, 5'd5, 64'h11);
        set_stage(2, 1, 1, 1, 5'd5, 64'h22);
        #1;
        n_cmp++; if (op1_data !== 64'h11) begin n_bad++; $display("FAIL prio_young got %h exp 11", op1_data); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL prio_stall got %0b exp 0", stall); end
        tick();
        set_stage(0, 0, 1, 1, 5'd5, 64'h11);
        #1;
        n_cmp++; if (op1_data !== 64'h22) begin n_bad++; $display("FAIL prio_old got %h exp 22", op1_data); end
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        clear_in();
        set_id(1, 1, 5'd0, 1, 5'd7, 1, 5'd0, 0, 0);
        rf_rs1_data = 64'h77;
        set_stage(2, 1, 1, 1, 5'd0, 64'hEE);
        set_stage(1, 1, 1, 1, 5'd7, 64'hAB);
        #1;
        n_cmp++; if (op1_data !== 64'h77) begin n_bad++; $display("FAIL x0_op1 got %h exp 77", op1_data); end
        n_cmp++; if (op2_data !== 64'hAB) begin n_bad++; $display("FAIL lu_op2 got %h exp ab", op2_data); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_nostall got %0b exp 0", stall); end
        tick();
        set_stage(0, 1, 1, 0, 5'd7, 64'hCC);
        c0 = stall_cnt;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b exp 1", stall); end
        n_cmp++; if (issue_fire !== 1'b0) begin n_bad++; $display("FAIL lu_fire got %0b exp 0", issue_fire); end
        tick();
        n_cmp++; if (stall_cnt !== c0 + 32'd1) begin n_bad++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, c0 + 32'd1); end
    endtask

    task automatic test_long_op();
        clear_in();
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL long_fire got %0b exp 1", issue_fire); end
        tick();
        n_cmp++; if (outstanding !== 2'd1) begin n_bad++; $display("FAIL long_out got %0d exp 1", outstanding); end
        set_id(1, 1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL long_stall%0d got %0b exp 1", k, stall); end
            tick();
        end
        set_cpl(1, 5'd9, 64'h99);
        #1;
        n_cmp++; if (op1_data !== 64'h99) begin n_bad++; $display("FAIL cpl_fwd got %h exp 99", op1_data); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL cpl_stall got %0b exp 0", stall); end
        tick();
        clear_in();
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL cpl_out got %0d exp 0", outstanding); end
        n_cmp++; if (stall_cnt !== mcnt) begin n_bad++; $display("FAIL long_cnt got %0d exp %0d", stall_cnt, mcnt); end
    endtask

    task automatic test_max_out();
        clear_in();
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 1);
        tick();
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 1);
        tick();
        n_cmp++; if (outstanding !== 2'd2) begin n_bad++; $display("FAIL max_out2 got %0d exp 2", outstanding); end
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL max_full got %0b exp 1", stall); end
        tick();
        set_cpl(1, 5'd1, 64'h1);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL max_cplstall got %0b exp 0", stall); end
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL max_cplfire got %0b exp 1", issue_fire); end
        tick();
        n_cmp++; if (outstanding !== 2'd2) begin n_bad++; $display("FAIL max_net got %0d exp 2", outstanding); end
        clear_in();
        set_cpl(1, 5'd2, 64'h2);
        tick();
        set_cpl(1, 5'd10, 64'h3);
        tick();
        set_cpl(0, 5'd0, 64'h0);
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL max_drain got %0d exp 0", outstanding); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL max_err got %0b exp 0", err); end
    endtask

    task automatic test_waw();
        clear_in();
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        tick();
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_stall%0d got %0b exp 1", k, stall); end
            tick();
        end
        set_cpl(1, 5'd3, 64'h33);
        #1;
        n_cmp++; if (issue_fire !== 1'b1) begin n_bad++; $display("FAIL waw_fire got %0b exp 1", issue_fire); end
        tick();
        clear_in();
        n_cmp++; if (outstanding !== 2'd0) begin n_bad++; $display("FAIL waw_out got %0d exp 0", outstanding); end
    endtask

    task automatic test_err();
        clear_in();
        set_cpl(1, 5'd4, 64'h4);
        tick();
        set_cpl(0, 5'd0, 64'h0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %0b exp 1", err); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %0b exp 1", err); end
    endtask

    task automatic test_rst_midflight();
        clear_in();
        set_id(1, 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1);
        tick();
        set_id(1, 1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0);
        tick();
        #1 rst = 1'b1;
        m_reset();
        #1;
        m_comb();
        n_cmp++; if (outstanding !== '0) begin n_bad++; $display("FAIL arst_out got %0d exp 0", outstanding); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL arst_cnt got %0d exp 0", stall_cnt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL arst_err got %0b exp 0", err); end
        n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL arst_busy got %0b exp %0b", stall, e_stall); end
        rst = 1'b0;
        clear_in();
        set_cpl(1, 5'd6, 64'h6);
        tick();
        set_cpl(0, 5'd0, 64'h0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL arst_lost got %0b exp 1", err); end
    endtask

    task automatic test_random();
        int st;
        for (int n = 0; n < 400; n++) begin
            set_id(logic'($urandom_range(99) < 85), logic'($urandom_range(1)),
                   5'($urandom_range(7)), logic'($urandom_range(1)),
                   5'($urandom_range(7)), logic'($urandom_range(1)),
                   5'($urandom_range(7)), logic'($urandom_range(1)),
                   logic'($urandom_range(99) < 30));
            rf_rs1_data = {$urandom, $urandom};
            rf_rs2_data = {$urandom, $urandom};
            for (int i = 0; i < NS; i++)
                set_stage(i, logic'($urandom_range(1)), logic'($urandom_range(1)),
                          logic'($urandom_range(99) < 75), 5'($urandom_range(7)),
                          {$urandom, $urandom});
            set_cpl(0, 5'd0, {$urandom, $urandom});
            if ($urandom_range(99) < 40) begin
                st = int'($urandom_range(31));
                for (int k = 0; k < 32; k++) begin
                    if (!cpl_valid && mbusy[(st + k) % 32]) begin
                        cpl_valid = 1'b1;
                        cpl_rd = 5'((st + k) % 32);
                    end
                end
            end
            if (!cpl_valid && $urandom_range(99) < 3) begin
                cpl_valid = 1'b1;
                cpl_rd = 5'($urandom_range(31));
            end
            #1;
            m_comb();
            n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall[%0d] got %0b exp %0b", n, stall, e_stall); end
            n_cmp++; if (issue_fire !== e_fire) begin n_bad++; $display("FAIL rnd_fire[%0d] got %0b exp %0b", n, issue_fire, e_fire); end
            n_cmp++; if (op1_data !== e_op1) begin n_bad++; $display("FAIL rnd_op1[%0d] got %h exp %h", n, op1_data, e_op1); end
            n_cmp++; if (op2_data !== e_op2) begin n_bad++; $display("FAIL rnd_op2[%0d] got %h exp %h", n, op2_data, e_op2); end
            tick();
            n_cmp++; if (outstanding !== OW'(mout)) begin n_bad++; $display("FAIL rnd_out[%0d] got %0d exp %0d", n, outstanding, mout); end
            n_cmp++; if (stall_cnt !== mcnt) begin n_bad++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", n, stall_cnt, mcnt); end
            n_cmp++; if (err !== merr) begin n_bad++; $display("FAIL rnd_err[%0d] got %0b exp %0b", n, err, merr); end
        end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_long_op();
        test_max_out();
        test_waw();
        test_err();
        test_rst_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_hazard_scoreboard.md
# ysyx_220053_hazard_scoreboard

Parametrised hazard and forwarding unit for the ysyx_220053 in-order pipeline. It replaces the fixed three-stage comparator logic in the core top. It generalises to NSTAGE post-decode stages, resolves each source operand independently, and adds a register scoreboard for variable-latency operations (mul/div) that complete out of band. It also tracks an outstanding-op limit and keeps a saturating stall counter. It sits beside the IDU and drives the ID-stage stall and the busa/busb operand values.

## Interface
- NREG, 32: architectural registers; x0 is never a hazard source.
- XLEN, 64: data width.
- NSTAGE, 3: tracked post-ID stages; index 0 is youngest (EX), index NSTAGE-1 is oldest (WB).
- MAX_OUT, 4: maximum in-flight long-latency ops (1..NREG-1).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_en  in  1  downstream accepts the ID instruction this cycle.
- id_rs1, id_rs2  in  $clog2(NREG)  source register indices.
- id_rs1_use, id_rs2_use  in  1  source is actually read.
- id_rd  in  $clog2(NREG)  destination register.
- id_rd_wen  in  1  instruction writes rd.
- id_long  in  1  instruction is a long-latency op that writes back via the completion port.
- rf_rs1_data, rf_rs2_data  in  XLEN  register-file read data.
- st_valid, st_wen, st_ready  in  NSTAGE  per stage: valid; writes rd; result available (a load in EX has st_ready=0).
- st_rd  in  NSTAGE*$clog2(NREG)  per-stage rd, packed, stage 0 in the LSBs.
- st_data  in  NSTAGE*XLEN  per-stage result, packed.
- cpl_valid  in  1  long op writes back this cycle.
- cpl_rd  in  $clog2(NREG)  long-op destination register.
- cpl_data  in  XLEN  long-op result.
- stall  out  1  hold ID this cycle.
- issue_fire  out  1  id_valid & id_en & ~stall.
- op1_data, op2_data  out  XLEN  resolved operands.
- outstanding  out  $clog2(MAX_OUT+1)  number of in-flight long ops.
- stall_cnt  out  32  saturating count of cycles with id_valid & stall.
- err  out  1  sticky flag: completion arrived for a register that is not busy.

## Operation
- A source matches when its use bit is set, its index is nonzero, and it equals a valid, writing stage's rd. Each source is checked independently; a zero rs2 must not mask an rs1 hazard.
- Forward priority per source: youngest matching stage, then cpl (cpl_valid & cpl_rd match), then rf data.
- If the selected matching stage has st_ready=0, stall (load-use).
- busy[NREG] scoreboard: effective busy is busy[r] & ~(cpl_valid & cpl_rd==r), so a same-cycle completion is seen as free and its data is forwarded.
- Stall when any of the following holds:
  - a used source is effectively busy and no pipeline stage matches it;
  - id_rd_wen and rd!=0 and rd is effectively busy (WAW);
  - id_long and outstanding==MAX_OUT and no completion this cycle.
- stall is asserted only when id_valid=1.
- On an issue_fire edge with id_long & id_rd_wen & rd!=0: set busy[rd] and increment outstanding.
- On a cpl_valid edge: if busy[cpl_rd], clear it and decrement outstanding; otherwise set err.
- Issue and completion in the same cycle: net outstanding change is 0. Issue and completion to the same rd: busy ends set.
- stall_cnt saturates at 2^32-1.

## Timing
- stall, issue_fire, op1_data and op2_data are purely combinational, with zero latency.
- busy, outstanding, stall_cnt and err update on the rising clk edge.
- A long op issued at edge N is visible as busy to the instruction in ID in cycle N+1.
- A completion in cycle C unblocks a dependent in cycle C itself, via forwarding.
- Reset (asynchronous, any time, including mid-operation): busy=0, outstanding=0, stall_cnt=0, err=0. In-flight ops are forgotten; later completions for them set err.
- Reset values of the combinational outputs with all inputs at 0: stall=0, issue_fire=0, op1/op2 data = rf data (0).

## Structure
- Package ysyx_220053_hazard_pkg holds:
  - the RW = $clog2(NREG) localparam helper;
  - the forward-source enum FWD_RF, FWD_STAGE, FWD_CPL;
  - a stage-unpack function.
- Sub-module ysyx_220053_fwd_resolve handles one operand: match, priority, ready check, data mux. It is instantiated twice, and outputs need_stall and data.

## Test plan
- Stage 0 writes x5=0x11, stage 2 writes x5=0x22, ID reads rs1=x5 -> op1=0x11, stall=0.
- ID has rs1=x0, rs2=x7, stage 1 writes x7=0xAB with ready=1 -> op2=0xAB, no stall. Same ID with stage 0 load to x7 (ready=0) -> stall=1 and stall_cnt increments.
- Issue long op to x9; the next ID reads x9 -> stall for 4 cycles. Then cpl_valid with x9=0x99 -> same-cycle op1=0x99, stall=0, busy cleared, outstanding back to 0.
- MAX_OUT=2: two long ops to x1 and x2, then a third long op -> stall. A completion to x1 in the same cycle -> third op issues; outstanding stays 2.
- WAW: long op to x3 in flight, then ALU op writing x3 -> stall until completion.
- cpl_valid to non-busy x4 -> err=1 and it stays set. Assert rst mid-flight -> all counters, busy and err are 0 immediately, without waiting for a clock edge.
